// File: rtl/jk_ff_exerciser.sv
// Self-test sequencer for a JK flip-flop with active-low async set/reset.
// Applies LFSR-derived vectors, tracks the expected q in a reference model, and reports the results.
module jk_ff_exerciser #(
  parameter int          NUM_VEC = 16,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] fail_idx,
  output logic       ff_j,
  output logic       ff_k,
  output logic       ff_set,
  output logic       ff_reset,
  input  logic       ff_q,
  input  logic       ff_qb
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_lfsr;
  logic [7:0] r_idx;
  logic       r_exp_q;
  logic [7:0] w_lfsr_next;
  logic       w_mismatch;

  // Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Returns {set_n, reset_n, j, k}; set_n and reset_n can never both be low.
  function automatic logic [3:0] vec_decode(input logic [2:0] hi, input logic [1:0] lo);
    return {~&hi, |hi, lo[0], lo[1]};
  endfunction

  function automatic logic ref_next(input logic q, input logic j, input logic k,
                                    input logic set_n, input logic reset_n);
    logic nq;
    nq = q;
    if (!set_n)        nq = 1'b1;
    else if (!reset_n) nq = 1'b0;
    else begin
      case ({j, k})
        2'b01:   nq = 1'b0;
        2'b10:   nq = 1'b1;
        2'b11:   nq = ~q;
        default: nq = q;
      endcase
    end
    return nq;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_lfsr_next = lfsr_step(r_lfsr);
  assign w_mismatch  = (ff_q != r_exp_q) || (ff_qb != ~ff_q);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_INIT;
      S_INIT:  w_next = S_APPLY;
      S_APPLY: w_next = S_WAIT;
      S_WAIT:  w_next = S_CHECK;
      S_CHECK: w_next = (r_idx == LAST_IDX) ? S_DONE : S_APPLY;
      S_DONE:  if (start) w_next = S_INIT;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered on the edge that enters each state, so they are valid throughout it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr    <= SEED_EFF;
      r_idx     <= 8'd0;
      r_exp_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      fail_idx  <= 8'd0;
      ff_j      <= 1'b0;
      ff_k      <= 1'b0;
      ff_set    <= 1'b1;
      ff_reset  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_lfsr    <= SEED_EFF;
            r_idx     <= 8'd0;
            r_exp_q   <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'd0;
            fail_idx  <= 8'd0;
            ff_j      <= 1'b0;
            ff_k      <= 1'b0;
            ff_set    <= 1'b1;
            ff_reset  <= 1'b0;
          end
        end
        S_INIT: {ff_set, ff_reset, ff_j, ff_k} <= vec_decode(r_lfsr[7:5], r_lfsr[1:0]);
        S_APPLY: r_exp_q <= ref_next(r_exp_q, ff_j, ff_k, ff_set, ff_reset);
        S_WAIT: begin
          // Flip-flop has settled on the vector sampled at the edge entering WAIT.
          if (w_mismatch) begin
            err_count <= sat_inc(err_count);
            if (err_count == 8'd0) fail_idx <= r_idx;
          end
        end
        S_CHECK: begin
          r_lfsr <= w_lfsr_next;
          r_idx  <= r_idx + 8'd1;
          if (r_idx == LAST_IDX) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (err_count == 8'd0);
            ff_j     <= 1'b0;
            ff_k     <= 1'b0;
            ff_set   <= 1'b1;
            ff_reset <= 1'b1;
          end else begin
            {ff_set, ff_reset, ff_j, ff_k} <= vec_decode(w_lfsr_next[7:5], w_lfsr_next[1:0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_ff_exerciser.sv
// Bench for jk_ff_exerciser: behavioural JK flip-flops with injectable output faults,
// a vector-level reference model feeding a scoreboard, and a monitor that checks each finished run.
module tb_jk_ff_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start0, start1;
  logic busy0, done0, pass0, j0, k0, s0, r0, q0, fq0, fqb0;
  logic busy1, done1, pass1, j1, k1, s1, r1, q1, fq1, fqb1;
  logic [7:0] err0, fidx0, err1, fidx1;
  int mode = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic pd0 = 1'b0;
  logic pd1 = 1'b0;

  typedef struct {
    int   done_cyc;
    logic pass;
    int   err;
    int   fidx;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  always @(posedge clk) cyc <= cyc + 1;

  jk_ff_exerciser #(.NUM_VEC(16), .SEED(8'hA5)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_idx(fidx0), .ff_j(j0), .ff_k(k0), .ff_set(s0), .ff_reset(r0),
    .ff_q(fq0), .ff_qb(fqb0));

  jk_ff_exerciser #(.NUM_VEC(1), .SEED(8'h00)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_idx(fidx1), .ff_j(j1), .ff_k(k1), .ff_set(s1), .ff_reset(r1),
    .ff_q(fq1), .ff_qb(fqb1));

  // Behavioural flip-flops under test
  always @(posedge clk or negedge s0 or negedge r0) begin
    if (!s0)      q0 <= 1'b1;
    else if (!r0) q0 <= 1'b0;
    else case ({j0, k0})
      2'b01:   q0 <= 1'b0;
      2'b10:   q0 <= 1'b1;
      2'b11:   q0 <= ~q0;
      default: q0 <= q0;
    endcase
  end

  always @(posedge clk or negedge s1 or negedge r1) begin
    if (!s1)      q1 <= 1'b1;
    else if (!r1) q1 <= 1'b0;
    else case ({j1, k1})
      2'b01:   q1 <= 1'b0;
      2'b10:   q1 <= 1'b1;
      2'b11:   q1 <= ~q1;
      default: q1 <= q1;
    endcase
  end

  // mode 1: q stuck at 0; mode 2: qb shorted to q
  assign fq0  = (mode == 1) ? 1'b0 : q0;
  assign fqb0 = (mode == 2) ? fq0 : ~q0;
  assign fq1  = q1;
  assign fqb1 = ~q1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Vector-level model: walk the LFSR sequence and apply the flip-flop rules per vector.
  task automatic model(input logic [7:0] seed, input int n, input int fmode,
                       output logic mpass, output int merr, output int mfidx);
    logic [7:0] l;
    logic q, fail;
    int top;
    l = (seed == 8'h00) ? 8'h01 : seed;
    q = 1'b0;
    merr = 0;
    mfidx = 0;
    for (int v = 0; v < n; v++) begin
      top = int'(l) / 32;
      if (top == 7)                   q = 1'b1;
      else if (top == 0)              q = 1'b0;
      else if (l[0] && l[1])          q = ~q;
      else if (l[0])                  q = 1'b1;
      else if (l[1])                  q = 1'b0;
      fail = (fmode == 2) || (fmode == 1 && q);
      if (fail) begin
        if (merr == 0) mfidx = v;
        if (merr < 255) merr++;
      end
      l = {l[6:0], ^(l & 8'hB8)};
    end
    mpass = (merr == 0);
  endtask

  task automatic push(input int inst, input int e0, input logic [7:0] seed, input int n,
                      input int fmode);
    exp_t e;
    model(seed, n, fmode, e.pass, e.err, e.fidx);
    e.done_cyc = e0 + 3 * n + 1;
    if (inst == 0) sb0.push_back(e);
    else           sb1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue0(output int e0);
    start0 = 1'b1;
    tick();
    e0 = cyc;
    start0 = 1'b0;
    push(0, e0, 8'hA5, 16, mode);
  endtask

  task automatic wait_done(input int inst, input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      if ((inst == 0) ? done0 : done1) begin
        got = 1;
        break;
      end
      tick();
    end
    chk((inst == 0) ? "done0_within_budget" : "done1_within_budget", got, 1);
  endtask

  task automatic check_rst();
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_fidx", fidx0, 0);
    chk("rst_j", j0, 0);
    chk("rst_k", k0, 0);
    chk("rst_set", s0, 1);
    chk("rst_reset", r0, 1);
    chk("rst1_done", done1, 0);
  endtask

  // Monitor: each rising done pops one expected run result.
  always @(negedge clk) begin
    exp_t e;
    if (done0 && !pd0) begin
      if (sb0.size() == 0) chk("sb0_unexpected_done", 1, 0);
      else begin
        e = sb0.pop_front();
        chk("done0_cycle", cyc, e.done_cyc);
        chk("pass0", pass0, e.pass);
        chk("err0", err0, e.err);
        chk("fidx0", fidx0, e.fidx);
        chk("busy0_at_done", busy0, 0);
      end
    end
    if (done1 && !pd1) begin
      if (sb1.size() == 0) chk("sb1_unexpected_done", 1, 0);
      else begin
        e = sb1.pop_front();
        chk("done1_cycle", cyc, e.done_cyc);
        chk("pass1", pass1, e.pass);
        chk("err1", err1, e.err);
        chk("fidx1", fidx1, e.fidx);
      end
    end
    pd0 = done0;
    pd1 = done1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    reset = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_rst();

    // Known-good run, with a start pulse at E10 that must be ignored
    issue0(e0);
    chk("init_busy", busy0, 1);
    chk("init_ff_reset", r0, 0);
    chk("init_ff_set", s0, 1);
    tick();
    chk("vec0_j", j0, 1);
    chk("vec0_k", k0, 0);
    chk("vec0_set", s0, 1);
    chk("vec0_reset", r0, 1);
    while (cyc < e0 + 9) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("busy_mid_run", busy0, 1);
    wait_done(0, 100);

    // Stuck-at-0 q, then broken complement
    mode = 1;
    issue0(e0);
    wait_done(0, 100);
    mode = 2;
    issue0(e0);
    wait_done(0, 100);

    // Restart from DONE with errors pending: counters must clear in INIT
    mode = 0;
    issue0(e0);
    chk("restart_err_clear", err0, 0);
    chk("restart_fidx_clear", fidx0, 0);
    chk("restart_done_clear", done0, 0);
    wait_done(0, 100);

    // Reset mid-run at E20; the aborted run must never report
    start0 = 1'b1;
    tick();
    e0 = cyc;
    start0 = 1'b0;
    while (cyc < e0 + 19) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_rst();
    repeat (5) tick();
    chk("post_reset_idle_busy", busy0, 0);
    issue0(e0);
    wait_done(0, 100);

    // Random restarts with random faults
    for (int t = 0; t < 3; t++) begin
      mode = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 4)) tick();
      issue0(e0);
      wait_done(0, 100);
    end

    // Single-vector instance with SEED 0
    start1 = 1'b1;
    tick();
    e0 = cyc;
    start1 = 1'b0;
    push(1, e0, 8'h00, 1, 0);
    tick();
    chk("inst1_vec0_j", j1, 1);
    chk("inst1_vec0_k", k1, 0);
    wait_done(1, 20);

    repeat (3) tick();
    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
